// File: rtl/uart_in_feeder_if.sv
// rtl/uart_in_feeder_if.sv - host push / DUT read-request bundle for the UART input feeder
interface uart_in_feeder_if #(
    parameter int DEPTH = 16
) ();
    logic                    host_valid;
    logic [7:0]              host_ch;
    logic                    host_ready;
    logic                    io_uart_in_valid;
    logic [7:0]              io_uart_in_ch;
    logic [$clog2(DEPTH):0]  count;
    logic [31:0]             empty_reads;

    modport master (
        output host_valid, host_ch, io_uart_in_valid,
        input  host_ready, io_uart_in_ch, count, empty_reads
    );

    modport slave (
        input  host_valid, host_ch, io_uart_in_valid,
        output host_ready, io_uart_in_ch, count, empty_reads
    );
endinterface

// File: rtl/uart_in_feeder.sv
// rtl/uart_in_feeder.sv - paced FIFO feeding host characters to a polled UART input
module uart_in_feeder #(
    parameter int         DEPTH      = 16,
    parameter int         GAP_CYCLES = 0,
    parameter logic [7:0] EMPTY_CH   = 8'hff
) (
    input  logic            clock,
    input  logic            reset,
    uart_in_feeder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    logic [7:0]    mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [31:0]   empty_reads_q, empty_reads_d;

    logic avail;
    logic not_full;
    logic push;
    logic pop;

    always_comb begin
        avail    = (count_q != '0) && (gap_cnt_q == '0);
        not_full = (count_q < CW'(DEPTH));
        push     = bus.host_valid && not_full;
        pop      = bus.io_uart_in_valid && avail;

        // Pointers wrap naturally because DEPTH is a power of two.
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        gap_cnt_d = gap_cnt_q;
        if (pop) begin
            gap_cnt_d = GW'(GAP_CYCLES);
        end else if (gap_cnt_q != '0) begin
            gap_cnt_d = gap_cnt_q - GW'(1);
        end

        empty_reads_d = empty_reads_q;
        if (bus.io_uart_in_valid && !avail && (empty_reads_q != 32'hffff_ffff)) begin
            empty_reads_d = empty_reads_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            gap_cnt_q     <= '0;
            empty_reads_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            gap_cnt_q     <= gap_cnt_d;
            empty_reads_q <= empty_reads_d;
        end
    end

    // Storage is left unreset; a stray write during reset is harmless since pointers clear.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.host_ch;
        end
    end

    always_comb begin
        bus.host_ready    = not_full;
        bus.io_uart_in_ch = avail ? mem[rd_ptr_q] : EMPTY_CH;
        bus.count         = count_q;
        bus.empty_reads   = empty_reads_q;
    end
endmodule

// File: tb/tb_uart_in_feeder.sv
// tb/tb_uart_in_feeder.sv - scoreboard bench for uart_in_feeder at GAP_CYCLES 0 and 3
module tb_uart_in_feeder;
    localparam int DEPTH = 16;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    uart_in_feeder_if #(.DEPTH(DEPTH)) if0 ();
    uart_in_feeder_if #(.DEPTH(DEPTH)) if3 ();

    uart_in_feeder #(.DEPTH(DEPTH), .GAP_CYCLES(0), .EMPTY_CH(8'hff)) dut0 (
        .clock(clock), .reset(reset), .bus(if0.slave)
    );
    uart_in_feeder #(.DEPTH(DEPTH), .GAP_CYCLES(3), .EMPTY_CH(8'hff)) dut3 (
        .clock(clock), .reset(reset), .bus(if3.slave)
    );

    typedef struct {
        logic [7:0]  ch;
        logic        ready;
        logic [31:0] cnt;
        logic [31:0] er;
    } exp_t;

    exp_t exp0 [$];
    exp_t exp3 [$];

    // Reference model: a byte queue per DUT plus the earliest cycle a pop may happen.
    logic [7:0]  q0 [$];
    logic [7:0]  q3 [$];
    int          next_ok [2];
    logic [31:0] er_m [2];
    int          cyc = 0;

    int n_vec = 0;
    int n_bad = 0;

    function automatic int msize(input int d);
        return (d == 0) ? q0.size() : q3.size();
    endfunction

    function automatic logic [7:0] mhead(input int d);
        return (d == 0) ? q0[0] : q3[0];
    endfunction

    function automatic exp_t model_expect(input int d);
        exp_t e;
        logic ok;
        ok      = (msize(d) != 0) && (cyc >= next_ok[d]);
        e.ch    = ok ? mhead(d) : 8'hff;
        e.ready = (msize(d) < DEPTH);
        e.cnt   = 32'(msize(d));
        e.er    = er_m[d];
        return e;
    endfunction

    task automatic model_update(input int d, input logic hv, input logic [7:0] hch,
                                input logic iv, input logic rst);
        logic ok;
        logic full;
        int   gap;
        gap  = (d == 0) ? 0 : 3;
        ok   = (msize(d) != 0) && (cyc >= next_ok[d]);
        full = (msize(d) >= DEPTH);
        if (rst) begin
            if (d == 0) q0.delete(); else q3.delete();
            next_ok[d] = 0;
            er_m[d]    = 32'd0;
        end else begin
            if (iv && !ok && er_m[d] != 32'hffff_ffff) er_m[d] = er_m[d] + 32'd1;
            if (iv && ok) begin
                if (d == 0) void'(q0.pop_front()); else void'(q3.pop_front());
                next_ok[d] = cyc + gap + 1;
            end
            if (hv && !full) begin
                if (d == 0) q0.push_back(hch); else q3.push_back(hch);
            end
        end
    endtask

    task automatic step(input logic hv, input logic [7:0] hch, input logic iv,
                        input logic rst, input bit chk);
        if0.host_valid = hv; if0.host_ch = hch; if0.io_uart_in_valid = iv;
        if3.host_valid = hv; if3.host_ch = hch; if3.io_uart_in_valid = iv;
        reset = rst;
        if (chk) begin
            exp0.push_back(model_expect(0));
            exp3.push_back(model_expect(1));
        end
        @(posedge clock);
        model_update(0, hv, hch, iv, rst);
        model_update(1, hv, hch, iv, rst);
        cyc++;
        #1;
    endtask

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] ex);
        n_vec++;
        if (act !== ex) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got 0x%0h expected 0x%0h", nm, $time, act, ex);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (exp0.size() > 0) begin
            e = exp0.pop_front();
            cmp("g0_ch",          32'(if0.io_uart_in_ch), 32'(e.ch));
            cmp("g0_host_ready",  32'(if0.host_ready),    32'(e.ready));
            cmp("g0_count",       32'(if0.count),         e.cnt);
            cmp("g0_empty_reads", if0.empty_reads,        e.er);
        end
        if (exp3.size() > 0) begin
            e = exp3.pop_front();
            cmp("g3_ch",          32'(if3.io_uart_in_ch), 32'(e.ch));
            cmp("g3_host_ready",  32'(if3.host_ready),    32'(e.ready));
            cmp("g3_count",       32'(if3.count),         e.cnt);
            cmp("g3_empty_reads", if3.empty_reads,        e.er);
        end
    end

    initial begin
        next_ok[0] = 0; next_ok[1] = 0;
        er_m[0] = 32'd0; er_m[1] = 32'd0;
        if0.host_valid = 1'b0; if0.host_ch = 8'h00; if0.io_uart_in_valid = 1'b0;
        if3.host_valid = 1'b0; if3.host_ch = 8'h00; if3.io_uart_in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Reset state, then idle.
        step(0, 8'h00, 0, 1, 0);
        step(0, 8'h00, 0, 1, 1);
        step(0, 8'h00, 0, 0, 1);

        // Ordering.
        step(1, 8'h41, 0, 0, 1);
        step(1, 8'h42, 0, 0, 1);
        step(1, 8'h43, 0, 0, 1);
        for (int i = 0; i < 12; i++) step(0, 8'h00, 1, 0, 1);
        step(0, 8'h00, 0, 0, 1);

        // Empty reads, then push alongside a request (no bypass).
        step(0, 8'h00, 1, 0, 1);
        step(0, 8'h00, 1, 0, 1);
        step(1, 8'h55, 1, 0, 1);
        step(0, 8'h00, 1, 0, 1);
        step(0, 8'h00, 0, 0, 1);

        // Full and wrap-around.
        for (int i = 0; i < 20; i++) step(1, 8'(i), 0, 0, 1);
        for (int i = 0; i < 8; i++)  step(0, 8'h00, 1, 0, 1);
        for (int i = 0; i < 8; i++)  step(1, 8'(8'h80 + i), 0, 0, 1);
        for (int i = 0; i < 80; i++) step(0, 8'h00, 1, 0, 1);

        // Pacing with two bytes buffered and the request held.
        step(1, 8'hA1, 0, 0, 1);
        step(1, 8'hA2, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0, 1);

        // Simultaneous push/pop at count 5.
        for (int i = 0; i < 5; i++) step(1, 8'(8'hB0 + i), 0, 0, 1);
        for (int i = 0; i < 6; i++) step(1, 8'(8'hC0 + i), 1, 0, 1);
        for (int i = 0; i < 40; i++) step(0, 8'h00, 1, 0, 1);

        // Reset mid-operation with a gap pending.
        for (int i = 0; i < 8; i++) step(1, 8'(8'hD0 + i), 0, 0, 1);
        step(0, 8'h00, 1, 0, 1);
        step(0, 8'h00, 1, 0, 1);
        step(0, 8'h00, 0, 1, 1);
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 1, 0, 1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50,
                 $urandom_range(0, 299) == 0, 1);
        end
        step(0, 8'h00, 0, 0, 1);

        for (int i = 0; i < 4 && (exp0.size() != 0 || exp3.size() != 0); i++) @(posedge clock);
        n_vec++;
        if (exp0.size() != 0 || exp3.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d/%0d expectations left, required 0", exp0.size(), exp3.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_in_feeder.md
UART_IN_FEEDER -- requirements
Module: uart_in_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter GAP_CYCLES, default 0, meaning minimum idle cycles enforced after each delivered character.
REQ-003 SHALL have parameter EMPTY_CH, default 8'hff, meaning the value returned when no character is deliverable.
REQ-004 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port host_valid  input  1  host offers a character.
REQ-007 SHALL have port host_ch  input  8  character offered by the host.
REQ-008 SHALL have port host_ready  output  1  feeder accepts host_ch this cycle.
REQ-009 SHALL have port io_uart_in_valid  input  1  DUT read request (one character per asserted cycle).
REQ-010 SHALL have port io_uart_in_ch  output  8  character returned to the DUT.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  number of buffered characters.
REQ-012 SHALL have port empty_reads  output  32  number of DUT requests answered with EMPTY_CH.

Function
REQ-013 SHALL implement a DEPTH-entry circular FIFO with write and read pointers wrapping modulo DEPTH.
REQ-014 SHALL drive host_ready = (count < DEPTH); a push occurs on a rising edge when host_valid && host_ready.
REQ-015 SHALL ignore host_valid while full: no write, no pointer or count change.
REQ-016 SHALL define avail = (count != 0) && (gap_cnt == 0).
REQ-017 SHALL drive io_uart_in_ch combinationally: FIFO head when avail, else EMPTY_CH, regardless of io_uart_in_valid (zero-latency response in the request cycle).
REQ-018 SHALL pop the head on a rising edge when io_uart_in_valid && avail.
REQ-019 SHALL, on a pop, load gap_cnt with GAP_CYCLES; otherwise decrement gap_cnt each cycle while nonzero.
REQ-020 SHALL, with GAP_CYCLES=0, permit back-to-back pops on consecutive cycles.
REQ-021 SHALL, on io_uart_in_valid && !avail, increment empty_reads, saturating at 32'hffffffff.
REQ-022 SHALL, on simultaneous push and pop, update count by net zero, with the pushed byte written behind the popped one.
REQ-023 SHALL NOT bypass: a byte pushed in cycle N is deliverable no earlier than cycle N+1; a request in cycle N on an empty FIFO returns EMPTY_CH.
REQ-024 SHALL preserve byte order exactly (FIFO), including across pointer wrap-around.
REQ-025 SHALL update count as: +1 on push only, -1 on pop only, unchanged otherwise.

Reset
REQ-026 SHALL, while reset is high at a rising edge, clear write pointer, read pointer, count, gap_cnt and empty_reads to 0, discarding buffered data.
REQ-027 SHALL, during and immediately after reset, present host_ready=1, io_uart_in_ch=EMPTY_CH, count=0, empty_reads=0.
REQ-028 SHALL give reset priority over simultaneous push, pop or counter increment in the same cycle.
REQ-029 SHALL not require FIFO storage contents to be reset.

Verification
REQ-030 SHALL cover ordering: push 0x41,0x42,0x43, then in_valid 3 consecutive cycles -> in_ch 0x41,0x42,0x43, count 3->0, empty_reads 0.
REQ-031 SHALL cover empty read: in_valid on empty FIFO for 2 cycles -> in_ch 0xff both cycles, empty_reads=2; push in same cycle as request -> 0xff that cycle, byte returned next request.
REQ-032 SHALL cover full/wrap: push 20 bytes 0x00..0x13 with host_valid held -> host_ready drops after 16, count=16; pop 8, push 8 more, pop all -> sequence 0x00..0x0f then accepted later bytes in order, pointers wrapped.
REQ-033 SHALL cover pacing: GAP_CYCLES=3, 2 bytes buffered, in_valid held high -> first byte cycle 0, cycles 1-3 return 0xff (empty_reads +3), second byte cycle 4.
REQ-034 SHALL cover simultaneous push/pop at count=5 -> count stays 5, order intact.
REQ-035 SHALL cover reset mid-operation: count=7, gap_cnt>0, assert reset 1 cycle -> count=0, empty_reads=0, in_ch=0xff, host_ready=1 next cycle.
